// File: rtl/ccip_txn_tracker_pkg.sv
// Shared types, default parameters and helpers for the CCI-P transaction tracker.
package ccip_txn_tracker_pkg;
    localparam int DEF_NUM_CH        = 2;
    localparam int DEF_TAG_WIDTH     = 6;
    localparam int DEF_TS_WIDTH      = 16;
    localparam int DEF_TIMEOUT       = 4096;
    localparam int DEF_ALMFULL_SLACK = 8;
    localparam int DEF_CNT_WIDTH     = 32;

    // Widest supported timestamp; narrower instances zero-extend into it.
    localparam int TS_MAX = 32;
    typedef logic [TS_MAX-1:0] ts_t;

    typedef struct packed {
        logic valid;
        ts_t  issueTs;
    } trk_entry_t;

    // Modular age of an entry, wrapped to the instance timestamp width.
    function automatic ts_t latDelta(input ts_t now, input ts_t issue, input int tsWidth);
        ts_t mask;
        mask = (tsWidth >= TS_MAX) ? '1 : ((ts_t'(1) << tsWidth) - ts_t'(1));
        return (now - issue) & mask;
    endfunction
endpackage

// File: rtl/ccip_txn_tracker_if.sv
// CCI-P request/response observation bundle, one slice per channel.
interface ccip_txn_tracker_if #(
    parameter int NUM_CH    = 2,
    parameter int TAG_WIDTH = 6
);
    logic [NUM_CH-1:0]                req_valid;
    logic [NUM_CH-1:0][TAG_WIDTH-1:0] req_tag;
    logic [NUM_CH-1:0]                rsp_valid;
    logic [NUM_CH-1:0][TAG_WIDTH-1:0] rsp_tag;
    logic [NUM_CH-1:0]                alm_full;

    modport master (output req_valid, req_tag, rsp_valid, rsp_tag, alm_full);
    modport slave  (input  req_valid, req_tag, rsp_valid, rsp_tag, alm_full);
endinterface

// File: rtl/ccip_txn_tracker_tag_table.sv
// Per-channel tag table: valid/timestamp entries, outstanding count and timeout scan.
module ccip_tag_table
    import ccip_txn_tracker_pkg::*;
#(
    parameter int TAG_WIDTH = DEF_TAG_WIDTH,
    parameter int TS_WIDTH  = DEF_TS_WIDTH,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [TS_WIDTH-1:0]  ts,
    input  logic                 reqValid,
    input  logic [TAG_WIDTH-1:0] reqTag,
    input  logic                 rspValid,
    input  logic [TAG_WIDTH-1:0] rspTag,
    output logic                 rspHit,
    output logic [TS_WIDTH-1:0]  rspLat,
    output logic                 dupHit,
    output logic                 orphan,
    output logic                 timeoutHit,
    output logic [TAG_WIDTH-1:0] scanTag,
    output logic [TAG_WIDTH:0]   outstanding
);
    localparam int DEPTH = 2**TAG_WIDTH;

    logic [DEPTH-1:0]    vld, vldNext;
    logic [TS_WIDTH-1:0] issueTs [DEPTH];
    logic [TAG_WIDTH-1:0] scanPtr;
    trk_entry_t          rspEnt, scanEnt;
    ts_t                 scanAge;
    logic                sameTag, arm;

    // Response is resolved against pre-cycle state, then the request is applied.
    always_comb begin
        rspEnt.valid    = vld[rspTag];
        rspEnt.issueTs  = ts_t'(issueTs[rspTag]);
        scanEnt.valid   = vld[scanPtr];
        scanEnt.issueTs = ts_t'(issueTs[scanPtr]);
        scanAge    = latDelta(ts_t'(ts), scanEnt.issueTs, TS_WIDTH);
        rspLat     = TS_WIDTH'(latDelta(ts_t'(ts), rspEnt.issueTs, TS_WIDTH));
        sameTag    = rspValid && (rspTag == reqTag);
        rspHit     = rspValid && rspEnt.valid;
        orphan     = rspValid && !rspEnt.valid;
        dupHit     = reqValid && vld[reqTag] && !sameTag;
        arm        = reqValid && (!vld[reqTag] || sameTag);
        timeoutHit = scanEnt.valid && (scanAge >= ts_t'(TIMEOUT));
        scanTag    = scanPtr;
        vldNext    = vld;
        if (rspHit) vldNext[rspTag] = 1'b0;
        if (arm)    vldNext[reqTag] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld         <= '0;
            scanPtr     <= '0;
            outstanding <= '0;
        end else begin
            vld     <= vldNext;
            scanPtr <= scanPtr + TAG_WIDTH'(1);
            case ({arm, rspHit})
                2'b10:   outstanding <= outstanding + (TAG_WIDTH+1)'(1);
                2'b01:   outstanding <= outstanding - (TAG_WIDTH+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (arm) issueTs[reqTag] <= ts;
    end
endmodule

// File: rtl/ccip_txn_tracker.sv
// CCI-P transaction scoreboard: per-channel latency stats and sticky protocol errors.
module ccip_txn_tracker
    import ccip_txn_tracker_pkg::*;
#(
    parameter int NUM_CH        = DEF_NUM_CH,
    parameter int TAG_WIDTH     = DEF_TAG_WIDTH,
    parameter int TS_WIDTH      = DEF_TS_WIDTH,
    parameter int TIMEOUT       = DEF_TIMEOUT,
    parameter int ALMFULL_SLACK = DEF_ALMFULL_SLACK,
    parameter int CNT_WIDTH     = DEF_CNT_WIDTH
) (
    input  logic                                clk,
    input  logic                                SoftReset,
    ccip_txn_tracker_if.slave                   bus,
    input  logic                                clear_stats,
    output logic [NUM_CH-1:0][TAG_WIDTH:0]      outstanding,
    output logic [NUM_CH-1:0][CNT_WIDTH-1:0]    txn_count,
    output logic [NUM_CH-1:0][TS_WIDTH-1:0]     lat_min,
    output logic [NUM_CH-1:0][TS_WIDTH-1:0]     lat_max,
    output logic [NUM_CH-1:0]                   err_dup,
    output logic [NUM_CH-1:0]                   err_orphan,
    output logic [NUM_CH-1:0]                   err_timeout,
    output logic [NUM_CH-1:0]                   err_almfull,
    output logic [NUM_CH-1:0][TAG_WIDTH-1:0]    timeout_tag,
    output logic                                err_any
);
    localparam int SLACK_W = $clog2(ALMFULL_SLACK + 2);

    logic [TS_WIDTH-1:0]              ts;
    logic [NUM_CH-1:0]                reqV, rspV, almF;
    logic [NUM_CH-1:0][TAG_WIDTH-1:0] reqT, rspT, scanTag;
    logic                             clrQ;
    logic [NUM_CH-1:0]                rspHit, dupHit, orphan, toHit;
    logic [NUM_CH-1:0][TS_WIDTH-1:0]  rspLat;
    logic [NUM_CH-1:0]                dupN, orphN, toN, almN;

    // Boundary signals are captured first so table lookups run off flops.
    always_ff @(posedge clk or posedge SoftReset) begin
        if (SoftReset) begin
            ts      <= '0;
            reqV    <= '0;
            reqT    <= '0;
            rspV    <= '0;
            rspT    <= '0;
            almF    <= '0;
            clrQ    <= 1'b0;
            err_any <= 1'b0;
        end else begin
            ts      <= ts + TS_WIDTH'(1);
            reqV    <= bus.req_valid;
            reqT    <= bus.req_tag;
            rspV    <= bus.rsp_valid;
            rspT    <= bus.rsp_tag;
            almF    <= bus.alm_full;
            clrQ    <= clear_stats;
            err_any <= |{dupN, orphN, toN, almN};
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [CNT_WIDTH-1:0] txnQ;
        logic [TS_WIDTH-1:0]  minQ, maxQ;
        logic [TAG_WIDTH-1:0] toTagQ;
        logic [SLACK_W-1:0]   slack;
        logic                 dupQ, orphQ, toQ, afQ, almHit;

        ccip_tag_table #(.TAG_WIDTH(TAG_WIDTH), .TS_WIDTH(TS_WIDTH), .TIMEOUT(TIMEOUT)) u_tbl (
            .clk        (clk),
            .rst        (SoftReset),
            .ts         (ts),
            .reqValid   (reqV[c]),
            .reqTag     (reqT[c]),
            .rspValid   (rspV[c]),
            .rspTag     (rspT[c]),
            .rspHit     (rspHit[c]),
            .rspLat     (rspLat[c]),
            .dupHit     (dupHit[c]),
            .orphan     (orphan[c]),
            .timeoutHit (toHit[c]),
            .scanTag    (scanTag[c]),
            .outstanding(outstanding[c])
        );

        assign almHit  = almF[c] && reqV[c] && (slack == SLACK_W'(ALMFULL_SLACK));
        assign dupN[c]  = !clrQ && (dupQ  || dupHit[c]);
        assign orphN[c] = !clrQ && (orphQ || orphan[c]);
        assign toN[c]   = !clrQ && (toQ   || toHit[c]);
        assign almN[c]  = !clrQ && (afQ   || almHit);

        always_ff @(posedge clk or posedge SoftReset) begin
            if (SoftReset) begin
                txnQ <= '0; minQ <= '1; maxQ <= '0; toTagQ <= '0; slack <= '0;
                dupQ <= 1'b0; orphQ <= 1'b0; toQ <= 1'b0; afQ <= 1'b0;
            end else begin
                dupQ  <= dupN[c];
                orphQ <= orphN[c];
                toQ   <= toN[c];
                afQ   <= almN[c];
                if (clrQ) begin
                    txnQ <= '0; minQ <= '1; maxQ <= '0; toTagQ <= '0; slack <= '0;
                end else begin
                    if (rspHit[c]) begin
                        if (txnQ != '1)       txnQ <= txnQ + CNT_WIDTH'(1);
                        if (rspLat[c] < minQ) minQ <= rspLat[c];
                        if (rspLat[c] > maxQ) maxQ <= rspLat[c];
                    end
                    if (toHit[c] && !toQ) toTagQ <= scanTag[c];
                    if (!almF[c])
                        slack <= '0;
                    else if (reqV[c] && slack != SLACK_W'(ALMFULL_SLACK + 1))
                        slack <= slack + SLACK_W'(1);
                end
            end
        end

        assign txn_count[c]   = txnQ;
        assign lat_min[c]     = minQ;
        assign lat_max[c]     = maxQ;
        assign timeout_tag[c] = toTagQ;
        assign err_dup[c]     = dupQ;
        assign err_orphan[c]  = orphQ;
        assign err_timeout[c] = toQ;
        assign err_almfull[c] = afQ;
    end
endmodule

// File: tb/tb_ccip_txn_tracker.sv
// Directed bench for ccip_txn_tracker: latency, dup/orphan/timeout/almfull, wrap and re-arm.
module tb_ccip_txn_tracker;
    localparam int NC  = 2;
    localparam int TW  = 6;
    localparam int TSW = 16;
    localparam int CW  = 32;

    logic clk = 1'b0;
    logic SoftReset;
    logic clear_stats;
    logic [NC-1:0][TW:0]     outstanding;
    logic [NC-1:0][CW-1:0]   txn_count;
    logic [NC-1:0][TSW-1:0]  lat_min, lat_max;
    logic [NC-1:0]           err_dup, err_orphan, err_timeout, err_almfull;
    logic [NC-1:0][TW-1:0]   timeout_tag;
    logic                    err_any;

    ccip_txn_tracker_if #(.NUM_CH(NC), .TAG_WIDTH(TW)) bus ();

    ccip_txn_tracker #(
        .NUM_CH(NC), .TAG_WIDTH(TW), .TS_WIDTH(TSW), .TIMEOUT(64),
        .ALMFULL_SLACK(8), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .SoftReset(SoftReset), .bus(bus), .clear_stats(clear_stats),
        .outstanding(outstanding), .txn_count(txn_count), .lat_min(lat_min), .lat_max(lat_max),
        .err_dup(err_dup), .err_orphan(err_orphan), .err_timeout(err_timeout),
        .err_almfull(err_almfull), .timeout_tag(timeout_tag), .err_any(err_any)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int unsigned cyc = 0;

    always @(posedge clk) begin
        if (SoftReset) cyc <= 0;
        else           cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic req(input int ch, input logic [TW-1:0] tag);
        bus.req_valid[ch] = 1'b1;
        bus.req_tag[ch]   = tag;
        tick();
        bus.req_valid[ch] = 1'b0;
    endtask

    task automatic rsp(input int ch, input logic [TW-1:0] tag);
        bus.rsp_valid[ch] = 1'b1;
        bus.rsp_tag[ch]   = tag;
        tick();
        bus.rsp_valid[ch] = 1'b0;
    endtask

    task automatic reqrsp(input int ch, input logic [TW-1:0] qtag, input logic [TW-1:0] ptag);
        bus.req_valid[ch] = 1'b1;
        bus.req_tag[ch]   = qtag;
        bus.rsp_valid[ch] = 1'b1;
        bus.rsp_tag[ch]   = ptag;
        tick();
        bus.req_valid[ch] = 1'b0;
        bus.rsp_valid[ch] = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        idle(2);
    endtask

    initial begin
        SoftReset = 1'b1;
        clear_stats = 1'b0;
        bus.req_valid = '0; bus.req_tag = '0;
        bus.rsp_valid = '0; bus.rsp_tag = '0;
        bus.alm_full  = '0;
        idle(3);
        check("rst_outstanding", 64'(outstanding), 64'd0);
        check("rst_txn_count",   64'(txn_count),   64'd0);
        check("rst_lat_min",     64'(lat_min),     64'hFFFF_FFFF);
        check("rst_lat_max",     64'(lat_max),     64'd0);
        check("rst_errors", 64'({err_dup, err_orphan, err_timeout, err_almfull, timeout_tag}), 64'd0);
        check("rst_err_any",     64'(err_any),     64'd0);
        SoftReset = 1'b0;
        idle(10);

        // Basic latency on ch0
        req(0, 5);
        idle(31);
        rsp(0, 5);
        idle(2);
        check("lat_min0_32",  64'(lat_min[0]),     64'd32);
        check("lat_max0_32",  64'(lat_max[0]),     64'd32);
        check("txn0_1",       64'(txn_count[0]),   64'd1);
        check("outst0_0",     64'(outstanding[0]), 64'd0);
        check("lat_min1_idle",64'(lat_min[1]),     64'hFFFF);
        check("err_any_clean",64'(err_any),        64'd0);

        // Duplicate tag on ch1
        req(1, 3);
        req(1, 3);
        idle(2);
        check("err_dup1",     64'(err_dup[1]),     64'd1);
        check("err_dup0",     64'(err_dup[0]),     64'd0);
        check("outst1_dup",   64'(outstanding[1]), 64'd1);
        check("err_any_dup",  64'(err_any),        64'd1);
        rsp(1, 3);
        idle(2);
        check("outst1_drain", 64'(outstanding[1]), 64'd0);

        // Orphan response on ch0
        rsp(0, 9);
        idle(2);
        check("err_orphan0",  64'(err_orphan[0]),  64'd1);
        check("txn0_orphan",  64'(txn_count[0]),   64'd1);
        check("outst0_orph",  64'(outstanding[0]), 64'd0);

        // Timeout of tag 7 on ch0
        req(0, 7);
        idle(58);
        check("to0_early",    64'(err_timeout[0]), 64'd0);
        idle(80);
        check("to0_late",     64'(err_timeout[0]), 64'd1);
        check("to_tag0",      64'(timeout_tag[0]), 64'd7);
        check("to1_none",     64'(err_timeout[1]), 64'd0);
        check("outst0_to",    64'(outstanding[0]), 64'd1);
        rsp(0, 7);
        idle(2);
        pulse_clear();

        // Almost-full overrun on ch0
        bus.alm_full[0] = 1'b1;
        for (int i = 0; i < 8; i++) req(0, TW'(10 + i));
        idle(2);
        check("almf0_8req",   64'(err_almfull[0]), 64'd0);
        req(0, 18);
        idle(2);
        check("almf0_9req",   64'(err_almfull[0]), 64'd1);
        check("outst0_9",     64'(outstanding[0]), 64'd9);
        pulse_clear();
        check("clr_errors", 64'({err_dup, err_orphan, err_timeout, err_almfull}), 64'd0);
        check("clr_err_any",  64'(err_any),        64'd0);
        check("clr_to_tag",   64'(timeout_tag),    64'd0);
        check("clr_outst0",   64'(outstanding[0]), 64'd9);
        check("clr_txn",      64'(txn_count),      64'd0);
        check("clr_lat_min",  64'(lat_min),        64'hFFFF_FFFF);
        check("clr_lat_max",  64'(lat_max),        64'd0);
        bus.alm_full[0] = 1'b0;
        for (int i = 0; i < 9; i++) rsp(0, TW'(10 + i));
        idle(2);
        check("outst0_drain9",64'(outstanding[0]), 64'd0);
        check("txn0_9",       64'(txn_count[0]),   64'd9);

        // Timestamp wrap: issue just before 0xFFFF, respond after rollover
        while (cyc < 32'hFFEC) tick();
        pulse_clear();
        req(0, 1);
        idle(31);
        rsp(0, 1);
        idle(2);
        check("wrap_lat_min", 64'(lat_min[0]),     64'h20);
        check("wrap_lat_max", 64'(lat_max[0]),     64'h20);
        check("wrap_txn",     64'(txn_count[0]),   64'd1);

        // Same-cycle request/response on tag 2 re-arms with the new timestamp
        req(0, 2);
        idle(4);
        reqrsp(0, 2, 2);
        idle(2);
        check("rearm_outst",  64'(outstanding[0]), 64'd1);
        check("rearm_txn",    64'(txn_count[0]),   64'd2);
        check("rearm_lat5",   64'(lat_min[0]),     64'd5);
        check("rearm_orphan", 64'(err_orphan[0]),  64'd0);
        rsp(0, 2);
        idle(2);
        check("rearm_lat3",   64'(lat_min[0]),     64'd3);
        check("rearm_max",    64'(lat_max[0]),     64'h20);
        check("rearm_drain",  64'(outstanding[0]), 64'd0);

        // Same-cycle request/response, different tags
        req(0, 20);
        reqrsp(0, 21, 20);
        idle(2);
        check("diff_outst",   64'(outstanding[0]), 64'd1);
        check("diff_txn",     64'(txn_count[0]),   64'd4);
        check("diff_dup",     64'(err_dup[0]),     64'd0);
        rsp(0, 21);
        idle(2);
        check("diff_drain",   64'(outstanding[0]), 64'd0);

        // Reset mid-operation discards the live entry
        req(0, 4);
        idle(2);
        check("pre_rst_outst",64'(outstanding[0]), 64'd1);
        SoftReset = 1'b1;
        idle(2);
        SoftReset = 1'b0;
        idle(140);
        check("post_rst_outst",64'(outstanding[0]), 64'd0);
        check("post_rst_to",  64'(err_timeout),    64'd0);
        check("post_rst_any", 64'(err_any),        64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/ccip_txn_tracker.md
# ccip_txn_tracker

Parametrised, synthesizable CCI-P transaction scoreboard. It sits beside the AFU on the CCI-P boundary and tracks outstanding requests per channel by mdata tag. It measures request-to-response latency and flags protocol violations in hardware: duplicate tags, orphan responses, timeouts and almost-full overrun. It is the on-chip successor to the simulation-only transaction logger, and its sticky status is readable over MMIO in both ASE and silicon.

## Interface
Parameters:
- NUM_CH, 2, number of tracked request/response channel pairs (ch0 = C0 read, ch1 = C1 write).
- TAG_WIDTH, 6, low mdata bits used as table index; table depth is 2**TAG_WIDTH per channel.
- TS_WIDTH, 16, free-running timestamp width; latencies are modulo 2**TS_WIDTH.
- TIMEOUT, 4096, age in cycles at which an outstanding entry is declared timed out; must be < 2**(TS_WIDTH-1).
- ALMFULL_SLACK, 8, requests allowed per channel after almost-full rises.
- CNT_WIDTH, 32, width of the saturating transaction counters.

Ports:
- clk  in  1  clock.
- SoftReset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_CH  request issued on channel i.
- req_tag  in  NUM_CH*TAG_WIDTH  request tag; channel i occupies slice i.
- rsp_valid  in  NUM_CH  response returned on channel i.
- rsp_tag  in  NUM_CH*TAG_WIDTH  response tag.
- alm_full  in  NUM_CH  TxAlmFull per channel.
- clear_stats  in  1  single-cycle pulse that clears statistics and sticky errors.
- outstanding  out  NUM_CH*(TAG_WIDTH+1)  live valid-entry count.
- txn_count  out  NUM_CH*CNT_WIDTH  completed transactions, saturating.
- lat_min  out  NUM_CH*TS_WIDTH  minimum observed latency.
- lat_max  out  NUM_CH*TS_WIDTH  maximum observed latency.
- err_dup, err_orphan, err_timeout, err_almfull  out  NUM_CH each  sticky error flags.
- timeout_tag  out  NUM_CH*TAG_WIDTH  tag of the first timeout per channel.
- err_any  out  1  OR of all error flags.

## Operation
- Each channel keeps a tag table: a valid bit plus a TS_WIDTH issue timestamp per entry. A global ts counter increments every cycle and wraps.
- Request, entry invalid: set valid, store ts, increment outstanding.
- Request, entry valid: set err_dup. The entry and its original timestamp are unchanged, and outstanding is unchanged.
- Response, entry valid: clear the entry and compute lat = ts - issue_ts (mod 2**TS_WIDTH). Update lat_min and lat_max, increment txn_count (saturating at all-ones), decrement outstanding.
- Response, entry invalid: set err_orphan. Nothing else changes.
- Request and response in the same cycle, same channel, same tag: the response is evaluated first against the pre-cycle state, then the request.
  - If the entry was valid: latency is recorded and the entry is re-armed with the current ts. outstanding is unchanged.
  - If the entry was invalid: err_orphan is set and the entry is armed by the request.
- Request and response in the same cycle, different tags: both take effect. Net outstanding is unchanged.
- Timeout scan: a per-channel round-robin pointer visits one entry per cycle and wraps after 2**TAG_WIDTH entries. A valid entry with (ts - issue_ts) >= TIMEOUT sets err_timeout. The first such tag is latched in timeout_tag until clear_stats. The entry stays valid.
- Almost-full check, per channel:
  - The slack counter clears while alm_full = 0.
  - While alm_full = 1, each request increments the counter, saturating at ALMFULL_SLACK+1.
  - A request that arrives when the count already equals ALMFULL_SLACK sets err_almfull.
- clear_stats clears txn_count, lat_max (to 0), lat_min (to all-ones), all sticky errors, timeout_tag and the slack counters. It does not clear tag tables or outstanding. An event in the same cycle as clear_stats is lost from the stats; clear wins.

## Timing
- All outputs are registered. Every output reflects an input event one cycle after the clock edge that samples it.
- A response sampled at edge N is visible on lat_min, lat_max and txn_count after edge N+1.
- A timeout is flagged within 2**TAG_WIDTH cycles of the entry's age reaching TIMEOUT.
- Reset values:
  - outstanding, txn_count, lat_max, errors, timeout_tag, err_any, ts and scan pointers: 0.
  - lat_min: all-ones.
  - Tag valid bits: all 0.
- Asserting reset mid-operation discards all outstanding entries. No errors are raised for those entries after reset releases.

## Structure
- Add to ase_pkg: a tracker entry typedef (valid, issue_ts), the latency-delta helper function, and the default parameter constants.
- Sub-module ccip_tag_table, instantiated NUM_CH times via generate, contains:
  - the entry array with one write port (request/response merge) and one scan read port;
  - the outstanding counter;
  - the timeout scan pointer.
- The top level holds ts, the per-channel statistics, the slack counters and the error aggregation.

## Test plan
- Issue a ch0 request with tag 5 at ts=10 and its response at ts=42 -> lat_min = lat_max = 32, txn_count = 1, outstanding back to 0.
- Send two ch1 requests with tag 3 and no response in between -> err_dup[1] = 1, outstanding[1] = 1.
- Send a ch0 response with tag 9 and no prior request -> err_orphan[0] = 1, txn_count unchanged.
- Issue a request with tag 7 with TIMEOUT=64, TAG_WIDTH=6 and never respond -> err_timeout[0] = 1 between cycle 64 and cycle 128, timeout_tag[0] = 7.
- Hold alm_full[0] = 1 and issue 9 requests -> err_almfull[0] set on the 9th request only. Then pulse clear_stats -> all errors 0, outstanding[0] = 9.
- Set ts near wrap (issue at 0xFFF0, respond at 0x0010) -> latency 0x20. Then send same-cycle request and response on tag 2 -> entry re-armed, outstanding unchanged.
